// File: rtl/arb_pkg.sv
// Shared constants, types and helpers for the four-port arbitrated request queue.
package arb_pkg;
  localparam int NPORT         = 4;
  localparam int DEPTH_DEFAULT = 4;

  typedef logic [1:0] port_idx_t;

  // Lowest set bit of a grant vector; 0 when the vector is empty.
  function automatic port_idx_t lowest_idx(input logic [NPORT-1:0] v);
    port_idx_t idx;
    idx = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (v[i]) idx = port_idx_t'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/arb_req_fifo.sv
// Single-port FIFO holding one requester's queued payloads; pointers carry an extra wrap bit.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic          full,
  output logic          empty,
  output logic          nonempty_nxt,
  output logic [DW-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   wptr, rptr, occ, occ_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push, do_pop;

  assign occ     = wptr - rptr;
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  // A full FIFO refuses the push even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign occ_nxt = occ + (do_push ? ONE : '0) - (do_pop ? ONE : '0);
  assign nonempty_nxt = (occ_nxt != '0);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ONE;
      if (do_pop)  rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/arb_req_queue.sv
// Per-port request FIFOs feeding an external round-robin arbiter; the granted head is presented downstream.
// Optional per-port pop statistics are enabled with ARB_REQ_QUEUE_STATS_EN.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    in_valid,
  output logic [NPORT-1:0]    in_ready,
  input  logic [NPORT*DW-1:0] in_data,
  output logic [NPORT-1:0]    req,
  input  logic [NPORT-1:0]    gnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output port_idx_t           out_port,
`ifdef ARB_REQ_QUEUE_STATS_EN
  output logic [NPORT-1:0][15:0] pop_cnt,
`endif
  output logic                gnt_err
);
  logic [NPORT-1:0] full, empty, nonempty_nxt, push, pop;
  logic [DW-1:0]    head [NPORT];
  port_idx_t        sel;

  // Ports only accept data once reset has been released.
  assign in_ready = {NPORT{rst}} & ~full;
  assign push     = in_valid & in_ready;

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    arb_req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push         (push[g]),
      .pop          (pop[g]),
      .wdata        (in_data[g*DW +: DW]),
      .full         (full[g]),
      .empty        (empty[g]),
      .nonempty_nxt (nonempty_nxt[g]),
      .head         (head[g])
    );
  end

  always_comb begin
    sel       = lowest_idx(gnt);
    out_valid = (gnt != '0) && !empty[sel];
    out_data  = out_valid ? head[sel] : '0;
    out_port  = out_valid ? sel : '0;
    pop       = '0;
    pop[sel]  = out_valid && out_ready;
  end

  // Registered stage: request vector and multi-hot grant flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req     <= '0;
      gnt_err <= 1'b0;
    end else begin
      req     <= nonempty_nxt;
      gnt_err <= ($countones(gnt) > 1);
    end
  end

`ifdef ARB_REQ_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_cnt <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (pop[i] && (pop_cnt[i] != 16'hFFFF)) pop_cnt[i] <= pop_cnt[i] + 16'd1;
      end
    end
  end
`endif
endmodule
